// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 cache with one outstanding request and a valid/ready line port to memory.
// Optional hit/miss counters are enabled with `define L2_STATS_EN.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module l2_cache #(
  parameter int L2_SETS = 256
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  l2_req_valid,
  output logic                                  l2_req_ready,
  input  logic [`ADDR_BITS-`OFFSET_BITS-1:0]    l2_req_addr,
  input  logic                                  l2_req_rw,
  input  logic [`CACHELINE_BITS-1:0]            l2_req_data,
  output logic                                  l2_resp_valid,
  output logic [`CACHELINE_BITS-1:0]            l2_resp_data,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic [`ADDR_BITS-`OFFSET_BITS-1:0]    mem_req_addr,
  output logic                                  mem_req_rw,
  output logic [`CACHELINE_BITS-1:0]            mem_req_data,
  input  logic                                  mem_resp_valid,
  input  logic [`CACHELINE_BITS-1:0]            mem_resp_data
`ifdef L2_STATS_EN
  ,
  output logic [31:0]                           stat_hits,
  output logic [31:0]                           stat_misses
`endif
);

  localparam int SET_BITS       = $clog2(L2_SETS);
  localparam int LINE_ADDR_BITS = `ADDR_BITS - `OFFSET_BITS;
  localparam int TAG_BITS       = LINE_ADDR_BITS - SET_BITS;
  localparam int LINE_BITS      = `CACHELINE_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL_REQ, S_FILL_WAIT, S_RESP
  } state_e;

  state_e                      state_q;
  logic [LINE_ADDR_BITS-1:0]   req_addr_q;
  logic                        req_rw_q;
  logic [LINE_BITS-1:0]        req_data_q;
  logic [L2_SETS-1:0]          valid_q;
  logic [L2_SETS-1:0]          dirty_q;
  logic [TAG_BITS-1:0]         tag_mem  [L2_SETS];
  logic [LINE_BITS-1:0]        data_mem [L2_SETS];
  logic                        resp_valid_q;
  logic [LINE_BITS-1:0]        resp_data_q;
  logic                        mem_req_valid_q;
  logic                        mem_req_rw_q;
  logic [LINE_ADDR_BITS-1:0]   mem_req_addr_q;
  logic [LINE_BITS-1:0]        mem_req_data_q;

  logic [SET_BITS-1:0]         req_idx;
  logic [TAG_BITS-1:0]         req_tag;
  logic                        hit;
  logic                        victim_dirty;
  logic                        arr_we;
  logic [LINE_BITS-1:0]        arr_wdata;

  assign req_idx      = req_addr_q[SET_BITS-1:0];
  assign req_tag      = req_addr_q[LINE_ADDR_BITS-1:SET_BITS];
  assign hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

  assign l2_req_ready  = (state_q == S_IDLE);
  assign l2_resp_valid = resp_valid_q;
  assign l2_resp_data  = resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;

  // Every line install (write hit, full-line write miss, post-eviction write, fill) goes through one port.
  always_comb begin
    // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latch).
    arr_we    = 1'b0;
    arr_wdata = req_data_q;
    case (state_q)
      S_LOOKUP:    arr_we = req_rw_q && (hit || !victim_dirty);
      S_EVICT:     arr_we = req_rw_q && mem_req_ready;
      S_FILL_WAIT: begin
        if (mem_resp_valid) begin
          arr_we    = 1'b1;
          arr_wdata = mem_resp_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: tag/data arrays have no reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= arr_wdata;
    end
  end

  // NOTE: all sequential state uses <= so every branch sees the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      req_addr_q      <= '0;
      req_rw_q        <= 1'b0;
      req_data_q      <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (l2_req_valid) begin
            req_addr_q <= l2_req_addr;
            req_rw_q   <= l2_req_rw;
            req_data_q <= l2_req_data;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (req_rw_q) begin
              dirty_q[req_idx] <= 1'b1;
              state_q          <= S_IDLE;
            end else begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= data_mem[req_idx];
              state_q      <= S_RESP;
            end
          end else if (victim_dirty) begin
            mem_req_valid_q <= 1'b1;
            mem_req_rw_q    <= 1'b1;
            mem_req_addr_q  <= {tag_mem[req_idx], req_idx};
            mem_req_data_q  <= data_mem[req_idx];
            state_q         <= S_EVICT;
          end else if (req_rw_q) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b1;
            state_q          <= S_IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= req_addr_q;
            mem_req_data_q  <= '0;
            state_q         <= S_FILL_REQ;
          end
        end
        S_EVICT: begin
          if (mem_req_ready) begin
            // A write re-dirties the set with its own line; a read leaves it clean for the fill.
            valid_q[req_idx] <= req_rw_q ? 1'b1 : valid_q[req_idx];
            dirty_q[req_idx] <= req_rw_q;
            if (req_rw_q) begin
              mem_req_valid_q <= 1'b0;
              mem_req_rw_q    <= 1'b0;
              state_q         <= S_IDLE;
            end else begin
              mem_req_rw_q   <= 1'b0;
              mem_req_addr_q <= req_addr_q;
              mem_req_data_q <= '0;
              state_q        <= S_FILL_REQ;
            end
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
            resp_valid_q     <= 1'b1;
            resp_data_q      <= mem_resp_data;
            state_q          <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_data_q  <= '0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef L2_STATS_EN
  logic [31:0] stat_hits_q;
  logic [31:0] stat_misses_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) begin
        if (stat_hits_q != '1) stat_hits_q <= stat_hits_q + 32'd1;
      end else begin
        if (stat_misses_q != '1) stat_misses_q <= stat_misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule
